// File: rtl/exc_flush_ctrl_if.sv
// Signal bundle between MEM-stage exception detection, CP0 and fetch PC-select
// and the exception flush sequencer.
interface exc_flush_ctrl_if;
    logic [31:0] excepttypeM;
    logic [31:0] newpcM;
    logic [31:0] pcM;
    logic        is_in_delayslotM;
    logic [31:0] bad_addrM;
    logic        mem_busy;
    logic        pc_ready;

    logic        flush_all;
    logic        stall_req;
    logic        exc_commit;
    logic        eret_commit;
    logic [4:0]  exccode;
    logic [31:0] epc_out;
    logic        bd_out;
    logic [31:0] badvaddr_out;
    logic        badvaddr_we;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic        drain_timeout;

    modport master (
        output excepttypeM, newpcM, pcM, is_in_delayslotM, bad_addrM, mem_busy, pc_ready,
        input  flush_all, stall_req, exc_commit, eret_commit, exccode, epc_out, bd_out,
               badvaddr_out, badvaddr_we, redirect_valid, redirect_pc, busy, drain_timeout
    );

    modport slave (
        input  excepttypeM, newpcM, pcM, is_in_delayslotM, bad_addrM, mem_busy, pc_ready,
        output flush_all, stall_req, exc_commit, eret_commit, exccode, epc_out, bd_out,
               badvaddr_out, badvaddr_we, redirect_valid, redirect_pc, busy, drain_timeout
    );
endinterface

// File: rtl/exc_flush_ctrl.sv
// Exception/ERET sequencer: drain data bus, commit CP0 fields in one pulse,
// then hold a pipeline flush while fetch takes the redirect PC.
module exc_flush_ctrl #(
    parameter int unsigned DRAIN_MAX = 16,
    parameter int unsigned HOLDOFF   = 2
) (
    input logic           clk,
    input logic           rst,
    exc_flush_ctrl_if.slave bus
);

    localparam int unsigned CNT_MAX = (DRAIN_MAX > HOLDOFF) ? DRAIN_MAX : HOLDOFF;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 2);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF - 1);

    typedef enum logic [2:0] {StIdle, StDrain, StCommit, StRedirect, StHold} state_e;

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             w_capture;

    logic [31:0] r_type, r_newpc, r_pc, r_addr;
    logic        r_bd;

    logic w_is_eret, w_is_int, w_addr_exc;
    assign w_is_eret  = (r_type == 32'h0000_000e);
    assign w_is_int   = (r_type == 32'h0000_0001);
    assign w_addr_exc = (r_type == 32'h0000_0004) || (r_type == 32'h0000_0005);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_type    <= '0;
            r_newpc   <= '0;
            r_pc      <= '0;
            r_addr    <= '0;
            r_bd      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
            if (w_capture) begin
                r_type  <= bus.excepttypeM;
                r_newpc <= bus.newpcM;
                r_pc    <= bus.pcM;
                r_addr  <= bus.bad_addrM;
                r_bd    <= bus.is_in_delayslotM;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = r_timeout;
        w_capture     = 1'b0;
        case (r_state)
            StIdle: begin
                if (bus.excepttypeM != 32'h0) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = bus.mem_busy ? StDrain : StCommit;
                end
            end
            StDrain: begin
                if (!bus.mem_busy) begin
                    w_state_nxt = StCommit;
                end else if (r_cnt == DRAIN_LAST) begin
                    // Give up on the bus and record it; the sticky flag is for debug.
                    w_state_nxt   = StCommit;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StCommit: w_state_nxt = StRedirect;
            StRedirect: begin
                if (bus.pc_ready) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (HOLDOFF == 0) ? StIdle : StHold;
                end
            end
            StHold: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        bus.flush_all      = 1'b0;
        bus.stall_req      = 1'b0;
        bus.exc_commit     = 1'b0;
        bus.eret_commit    = 1'b0;
        bus.exccode        = 5'h00;
        bus.epc_out        = 32'h0;
        bus.bd_out         = 1'b0;
        bus.badvaddr_out   = 32'h0;
        bus.badvaddr_we    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.busy           = (r_state != StIdle);
        bus.drain_timeout  = r_timeout;
        case (r_state)
            StDrain: bus.stall_req = 1'b1;
            StCommit: begin
                bus.flush_all    = 1'b1;
                bus.exc_commit   = !w_is_eret;
                bus.eret_commit  = w_is_eret;
                bus.exccode      = w_is_int ? 5'h00 : r_type[4:0];
                bus.epc_out      = r_bd ? (r_pc - 32'd4) : r_pc;
                bus.bd_out       = r_bd;
                bus.badvaddr_out = r_addr;
                bus.badvaddr_we  = w_addr_exc;
            end
            StRedirect: begin
                bus.flush_all      = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = r_newpc;
            end
            StHold: bus.flush_all = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Directed bench for exc_flush_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_exc_flush_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    exc_flush_ctrl_if u_if ();

    exc_flush_ctrl #(
        .DRAIN_MAX (16),
        .HOLDOFF   (2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic present(input logic [31:0] typ, input logic [31:0] newpc,
                           input logic [31:0] pc, input logic bd, input logic [31:0] addr);
        u_if.excepttypeM      = typ;
        u_if.newpcM           = newpc;
        u_if.pcM              = pc;
        u_if.is_in_delayslotM = bd;
        u_if.bad_addrM        = addr;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (u_if.busy && k < 50) begin
            step();
            k++;
        end
        check("idle_timeout", {31'h0, u_if.busy}, 32'h0);
    endtask

    initial begin
        int cnt;
        present(32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        u_if.mem_busy = 1'b0;
        u_if.pc_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_busy",  {31'h0, u_if.busy}, 32'h0);
        check("rst_flush", {31'h0, u_if.flush_all}, 32'h0);
        check("rst_rv",    {31'h0, u_if.redirect_valid}, 32'h0);
        check("rst_to",    {31'h0, u_if.drain_timeout}, 32'h0);

        // 1: syscall, no drain
        present(32'h08, 32'hBFC0_0380, 32'hBFC0_0100, 1'b0, 32'h0);
        u_if.pc_ready = 1'b1;
        step();
        present(32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        check("sys_commit", {31'h0, u_if.exc_commit}, 32'h1);
        check("sys_eret",   {31'h0, u_if.eret_commit}, 32'h0);
        check("sys_code",   {27'h0, u_if.exccode}, 32'h08);
        check("sys_epc",    u_if.epc_out, 32'hBFC0_0100);
        check("sys_we",     {31'h0, u_if.badvaddr_we}, 32'h0);
        check("sys_flush",  {31'h0, u_if.flush_all}, 32'h1);
        step();
        check("sys_commit_pulse", {31'h0, u_if.exc_commit}, 32'h0);
        check("sys_rv",     {31'h0, u_if.redirect_valid}, 32'h1);
        check("sys_rpc",    u_if.redirect_pc, 32'hBFC0_0380);
        step();
        check("sys_hold_rv",    {31'h0, u_if.redirect_valid}, 32'h0);
        check("sys_hold_flush", {31'h0, u_if.flush_all}, 32'h1);
        step();
        check("sys_hold2_flush", {31'h0, u_if.flush_all}, 32'h1);
        step();
        check("sys_idle_flush", {31'h0, u_if.flush_all}, 32'h0);
        check("sys_idle_busy",  {31'h0, u_if.busy}, 32'h0);

        // 2: adel in delay slot
        present(32'h04, 32'hBFC0_0380, 32'h8000_0010, 1'b1, 32'h8000_0013);
        step();
        present(32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        check("adel_commit", {31'h0, u_if.exc_commit}, 32'h1);
        check("adel_code",   {27'h0, u_if.exccode}, 32'h04);
        check("adel_epc",    u_if.epc_out, 32'h8000_000C);
        check("adel_bd",     {31'h0, u_if.bd_out}, 32'h1);
        check("adel_we",     {31'h0, u_if.badvaddr_we}, 32'h1);
        check("adel_bva",    u_if.badvaddr_out, 32'h8000_0013);
        wait_idle();

        // 2b: EPC wraps below zero
        present(32'h05, 32'hBFC0_0380, 32'h0000_0000, 1'b1, 32'h0000_0101);
        step();
        present(32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        check("ades_epc_wrap", u_if.epc_out, 32'hFFFF_FFFC);
        check("ades_code",     {27'h0, u_if.exccode}, 32'h05);
        check("ades_we",       {31'h0, u_if.badvaddr_we}, 32'h1);
        wait_idle();

        // 3: interrupt with 5-cycle drain
        present(32'h01, 32'hBFC0_0380, 32'h8000_1000, 1'b0, 32'h0);
        u_if.mem_busy = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 1) present(32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
            if (u_if.stall_req) cnt++;
            if (i == 5) u_if.mem_busy = 1'b0;
        end
        step();
        check("int_stall_cycles", cnt, 32'd5);
        check("int_stall_off",    {31'h0, u_if.stall_req}, 32'h0);
        check("int_commit",       {31'h0, u_if.exc_commit}, 32'h1);
        check("int_code",         {27'h0, u_if.exccode}, 32'h00);
        check("int_to",           {31'h0, u_if.drain_timeout}, 32'h0);
        wait_idle();

        // 4: bus stuck busy -> timeout
        present(32'h0c, 32'hBFC0_0380, 32'h8000_2000, 1'b0, 32'h0);
        u_if.mem_busy = 1'b1;
        cnt = 0;
        step();
        present(32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 40 && !u_if.exc_commit; i++) begin
            if (u_if.stall_req) cnt++;
            step();
        end
        check("to_commit",       {31'h0, u_if.exc_commit}, 32'h1);
        check("to_stall_cycles", cnt, 32'd16);
        check("to_flag",         {31'h0, u_if.drain_timeout}, 32'h1);
        check("to_code",         {27'h0, u_if.exccode}, 32'h0c);
        u_if.mem_busy = 1'b0;
        wait_idle();
        check("to_sticky", {31'h0, u_if.drain_timeout}, 32'h1);

        // 5: eret with slow fetch
        present(32'h0e, 32'h8000_0200, 32'h8000_3000, 1'b0, 32'h0);
        u_if.pc_ready = 1'b0;
        step();
        present(32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        check("eret_commit", {31'h0, u_if.eret_commit}, 32'h1);
        check("eret_exc",    {31'h0, u_if.exc_commit}, 32'h0);
        cnt = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (u_if.redirect_valid) cnt++;
            check("eret_rpc", u_if.redirect_pc, 32'h8000_0200);
            if (i == 4) u_if.pc_ready = 1'b1;
        end
        step();
        check("eret_rv_cycles", cnt, 32'd4);
        check("eret_rv_off",    {31'h0, u_if.redirect_valid}, 32'h0);
        check("eret_hold",      {31'h0, u_if.flush_all}, 32'h1);
        wait_idle();

        // 6a: async reset during REDIRECT
        present(32'h08, 32'hBFC0_0380, 32'h8000_4000, 1'b0, 32'h0);
        u_if.pc_ready = 1'b0;
        step();
        present(32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        step();
        check("rst6_rv_before", {31'h0, u_if.redirect_valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rst6_busy",  {31'h0, u_if.busy}, 32'h0);
        check("rst6_flush", {31'h0, u_if.flush_all}, 32'h0);
        check("rst6_rv",    {31'h0, u_if.redirect_valid}, 32'h0);
        check("rst6_rpc",   u_if.redirect_pc, 32'h0);
        check("rst6_to",    {31'h0, u_if.drain_timeout}, 32'h0);
        step();
        rst = 1'b0;
        step();
        check("rst6_no_commit", {31'h0, u_if.exc_commit}, 32'h0);
        check("rst6_idle",      {31'h0, u_if.busy}, 32'h0);

        // 6b: second exception during HOLD is ignored
        u_if.pc_ready = 1'b1;
        present(32'h09, 32'hBFC0_0380, 32'h8000_5000, 1'b0, 32'h0);
        step();
        present(32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        check("bp_code", {27'h0, u_if.exccode}, 32'h09);
        step();
        step();
        check("hold_rv",    {31'h0, u_if.redirect_valid}, 32'h0);
        check("hold_flush", {31'h0, u_if.flush_all}, 32'h1);
        present(32'h0a, 32'h1234_5678, 32'h8000_6000, 1'b0, 32'h0);
        step();
        check("hold2_flush", {31'h0, u_if.flush_all}, 32'h1);
        step();
        present(32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        check("ign_busy",   {31'h0, u_if.busy}, 32'h0);
        step();
        check("ign_busy2",  {31'h0, u_if.busy}, 32'h0);
        check("ign_commit", {31'h0, u_if.exc_commit}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
